// File: rtl/i2s_audio_serializer.sv
// Single-sample-buffered I2S transmitter: divides audio_clk into BCLK, frames
// stereo words MSB-first with the one-BCLK I2S delay, and reports buffer status.
`timescale 1ns/1ps
module i2s_audio_serializer #(
  parameter int AUD_BIT_DEPTH = 24,
  parameter int SLOT_BITS     = 32,
  parameter int BCLK_DIV      = 4,
  parameter int CNT_WIDTH     = $clog2(2*SLOT_BITS)
) (
  input  logic                     audio_clk,
  input  logic                     reset_audio,
  input  logic [AUD_BIT_DEPTH-1:0] lsound_in,
  input  logic [AUD_BIT_DEPTH-1:0] rsound_in,
  input  logic                     sample_valid,
  input  logic                     mute,
  input  logic                     flag_clr,
  output logic                     frame_req,
  output logic                     i2s_bclk,
  output logic                     i2s_lrck,
  output logic                     i2s_sdata,
  output logic                     underrun,
  output logic                     overrun
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(BCLK_DIV-1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(2*SLOT_BITS-1);
  localparam logic [CNT_WIDTH-1:0] SLOT     = CNT_WIDTH'(SLOT_BITS);
  localparam logic [CNT_WIDTH-1:0] DEPTH    = CNT_WIDTH'(AUD_BIT_DEPTH);

  logic [DIV_W-1:0]         div_cnt_q, div_cnt_d;
  logic                     bclk_q, bclk_d, lrck_q, lrck_d, sdata_q, sdata_d;
  logic [CNT_WIDTH-1:0]     bit_cnt_q, bit_cnt_d, bit_cnt_nx;
  logic [AUD_BIT_DEPTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [AUD_BIT_DEPTH-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
  logic                     hold_valid_q, hold_valid_d, armed_q, armed_d;
  logic                     frame_req_q, underrun_q, underrun_d, overrun_q, overrun_d;

  logic                     tick, fall_evt, load, right, under_set, over_set;
  logic [CNT_WIDTH-1:0]     p, sh;
  logic [AUD_BIT_DEPTH-1:0] word, shifted;

  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d    = tick ? ~bclk_q : bclk_q;
    fall_evt  = tick & bclk_q;

    bit_cnt_nx = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + CNT_WIDTH'(1);
    bit_cnt_d  = fall_evt ? bit_cnt_nx : bit_cnt_q;
    load       = fall_evt && (bit_cnt_nx == '0);

    // Bit select is done as a left shift so the index width never matters;
    // p=0 is the I2S delay slot and p>DEPTH is trailing padding.
    right   = (bit_cnt_nx >= SLOT);
    p       = right ? bit_cnt_nx - SLOT : bit_cnt_nx;
    word    = right ? act_r_q : act_l_q;
    sh      = p - CNT_WIDTH'(1);
    shifted = word << sh;
    lrck_d  = fall_evt ? right : lrck_q;
    sdata_d = fall_evt ? ((p != '0) && (p <= DEPTH) && shifted[AUD_BIT_DEPTH-1]) : sdata_q;
  end

  always_comb begin
    hold_l_d     = hold_l_q;
    hold_r_d     = hold_r_q;
    hold_valid_d = hold_valid_q;
    act_l_d      = act_l_q;
    act_r_d      = act_r_q;
    armed_d      = armed_q;
    under_set    = 1'b0;
    over_set     = 1'b0;
    if (load) begin
      hold_valid_d = 1'b0;
      if (mute) begin
        act_l_d = '0;
        act_r_d = '0;
      end else if (hold_valid_q) begin
        act_l_d = hold_l_q;
        act_r_d = hold_r_q;
      end
      under_set = !hold_valid_q && armed_q;
    end
    // A capture on the load cycle refills the slot the load just emptied.
    if (sample_valid) begin
      hold_l_d     = lsound_in;
      hold_r_d     = rsound_in;
      hold_valid_d = 1'b1;
      armed_d      = 1'b1;
      over_set     = hold_valid_q && !load;
    end
    underrun_d = under_set | (underrun_q & ~flag_clr);
    overrun_d  = over_set  | (overrun_q  & ~flag_clr);
  end

  always_ff @(posedge audio_clk or posedge reset_audio) begin
    if (reset_audio) begin
      div_cnt_q    <= '0;
      bclk_q       <= 1'b0;
      lrck_q       <= 1'b0;
      sdata_q      <= 1'b0;
      bit_cnt_q    <= CNT_LAST;
      hold_l_q     <= '0;
      hold_r_q     <= '0;
      hold_valid_q <= 1'b0;
      act_l_q      <= '0;
      act_r_q      <= '0;
      armed_q      <= 1'b0;
      frame_req_q  <= 1'b0;
      underrun_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bclk_q       <= bclk_d;
      lrck_q       <= lrck_d;
      sdata_q      <= sdata_d;
      bit_cnt_q    <= bit_cnt_d;
      hold_l_q     <= hold_l_d;
      hold_r_q     <= hold_r_d;
      hold_valid_q <= hold_valid_d;
      act_l_q      <= act_l_d;
      act_r_q      <= act_r_d;
      armed_q      <= armed_d;
      frame_req_q  <= load;
      underrun_q   <= underrun_d;
      overrun_q    <= overrun_d;
    end
  end

  assign frame_req = frame_req_q;
  assign i2s_bclk  = bclk_q;
  assign i2s_lrck  = lrck_q;
  assign i2s_sdata = sdata_q;
  assign underrun  = underrun_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_i2s_audio_serializer.sv
// Directed bench: frames are captured on BCLK rising edges and compared against
// expected stereo words queued as stimulus is applied.
`timescale 1ns/1ps
module tb_i2s_audio_serializer;
  localparam int DW  = 24;
  localparam int DIV = 2;
  localparam int FB  = 64;
  localparam int FRAME_CLKS = 4*32*DIV;
  localparam logic [63:0] LR_EXP = 64'hFFFF_FFFF_0000_0000;

  logic          audio_clk = 1'b0;
  logic          reset_audio = 1'b1;
  logic [DW-1:0] lsound_in = '0, rsound_in = '0;
  logic          sample_valid = 1'b0, mute = 1'b0, flag_clr = 1'b0;
  logic          frame_req, i2s_bclk, i2s_lrck, i2s_sdata, underrun, overrun;

  typedef struct { logic [DW-1:0] l; logic [DW-1:0] r; } frame_t;
  frame_t sb[$];

  int checks = 0, errors = 0;
  int cyc = 0, last_fr = 0;

  i2s_audio_serializer #(.AUD_BIT_DEPTH(DW), .SLOT_BITS(32), .BCLK_DIV(DIV)) dut (
    .audio_clk(audio_clk), .reset_audio(reset_audio),
    .lsound_in(lsound_in), .rsound_in(rsound_in),
    .sample_valid(sample_valid), .mute(mute), .flag_clr(flag_clr),
    .frame_req(frame_req), .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck),
    .i2s_sdata(i2s_sdata), .underrun(underrun), .overrun(overrun)
  );

  always #5 audio_clk = ~audio_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit k of the result is sdata during BCLK k of a frame (left slot first).
  function automatic logic [63:0] build_sd(input logic [DW-1:0] l, input logic [DW-1:0] r);
    logic [63:0]   v;
    logic [DW-1:0] w;
    v = '0;
    for (int k = 0; k < FB; k++) begin
      int p;
      p = k % 32;
      w = (k < 32) ? l : r;
      if (p >= 1 && p <= DW) v[k] = w[DW-p];
    end
    return v;
  endfunction

  function automatic frame_t fr(input logic [DW-1:0] l, input logic [DW-1:0] r);
    frame_t f;
    f.l = l;
    f.r = r;
    return f;
  endfunction

  initial forever begin
    @(posedge audio_clk);
    cyc++;
  end

  // Frame monitor
  initial begin
    logic [63:0] mon_sd, mon_lr;
    int          mon_idx;
    bit          mon_act, fr_seen;
    logic        bclk_prev;
    frame_t      f;
    mon_sd = '0; mon_lr = '0; mon_idx = 0; mon_act = 0; fr_seen = 0; bclk_prev = 1'b0;
    forever begin
      @(negedge audio_clk);
      if (reset_audio) begin
        mon_act = 0;
        mon_idx = 0;
        fr_seen = 0;
      end else begin
        if (frame_req) begin
          if (fr_seen) chk("frame_period", 64'(cyc - last_fr), 64'(FRAME_CLKS));
          fr_seen = 1;
          last_fr = cyc;
          mon_act = 1;
          mon_idx = 0;
        end
        if (mon_act && i2s_bclk && !bclk_prev) begin
          mon_sd[mon_idx] = i2s_sdata;
          mon_lr[mon_idx] = i2s_lrck;
          mon_idx++;
          if (mon_idx == FB) begin
            mon_act = 0;
            if (sb.size() > 0) begin
              f = sb.pop_front();
              chk("sdata_frame", mon_sd, build_sd(f.l, f.r));
              chk("lrck_frame", mon_lr, LR_EXP);
            end
          end
        end
      end
      bclk_prev = i2s_bclk;
    end
  end

  task automatic wait_fr();
    int n = 0;
    do begin
      @(negedge audio_clk);
      n++;
    end while (!frame_req && n < FRAME_CLKS + 40);
    chk("frame_req_seen", 64'(frame_req), 64'd1);
  endtask

  // Leaves the caller at the negedge just before the next frame-load edge.
  task automatic wait_pre_load();
    int n = 0;
    while (cyc != last_fr + FRAME_CLKS - 1 && n < FRAME_CLKS + 40) begin
      @(negedge audio_clk);
      n++;
    end
    chk("preload_sync", 64'(cyc == last_fr + FRAME_CLKS - 1), 64'd1);
  endtask

  task automatic drive_sample(input logic [DW-1:0] l, input logic [DW-1:0] r);
    lsound_in    = l;
    rsound_in    = r;
    sample_valid = 1'b1;
    @(negedge audio_clk);
    sample_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    flag_clr = 1'b1;
    @(negedge audio_clk);
    flag_clr = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bclk"},  64'(i2s_bclk),  64'd0);
    chk({tag, "_lrck"},  64'(i2s_lrck),  64'd0);
    chk({tag, "_sdata"}, 64'(i2s_sdata), 64'd0);
    chk({tag, "_freq"},  64'(frame_req), 64'd0);
    chk({tag, "_under"}, 64'(underrun),  64'd0);
    chk({tag, "_over"},  64'(overrun),   64'd0);
  endtask

  task automatic release_and_chk_bclk();
    @(negedge audio_clk);
    reset_audio = 1'b0;
    @(negedge audio_clk);
    chk("bclk_edge1", 64'(i2s_bclk), 64'd0);
    @(negedge audio_clk);
    chk("bclk_rise_at_div", 64'(i2s_bclk), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then idle frames with no sample ever supplied
    repeat (3) @(negedge audio_clk);
    chk_zero("reset");
    release_and_chk_bclk();
    for (int i = 0; i < 3; i++) begin
      wait_fr();
      sb.push_back(fr('0, '0));
    end
    wait_fr();
    chk("idle_underrun", 64'(underrun), 64'd0);

    // Reset again; sample before the first frame load
    #3 reset_audio = 1'b1;
    #1 chk_zero("reset2");
    sb.delete();
    repeat (2) @(negedge audio_clk);
    reset_audio = 1'b0;
    sb.push_back(fr(24'h800001, 24'h7FFFFE));
    drive_sample(24'h800001, 24'h7FFFFE);
    wait_fr();
    chk("frame0_underrun", 64'(underrun), 64'd0);

    // Starved frame repeats the word and flags underrun
    wait_fr();
    sb.push_back(fr(24'h800001, 24'h7FFFFE));
    chk("starve_underrun", 64'(underrun), 64'd1);
    wait_fr();
    sb.push_back(fr(24'h800001, 24'h7FFFFE));
    pulse_clr();
    chk("clr_underrun", 64'(underrun), 64'd0);
    wait_pre_load();
    flag_clr = 1'b1;
    @(negedge audio_clk);
    flag_clr = 1'b0;
    chk("clr_set_frame_req", 64'(frame_req), 64'd1);
    chk("clr_set_underrun", 64'(underrun), 64'd1);
    sb.push_back(fr(24'h800001, 24'h7FFFFE));
    wait_fr();
    pulse_clr();
    chk("clr2_underrun", 64'(underrun), 64'd0);

    // Overrun: second sample wins
    drive_sample(24'h111111, 24'h222222);
    repeat (3) @(negedge audio_clk);
    chk("pre_overrun", 64'(overrun), 64'd0);
    drive_sample(24'hABCDEF, 24'h654321);
    chk("overrun_set", 64'(overrun), 64'd1);
    wait_fr();
    sb.push_back(fr(24'hABCDEF, 24'h654321));
    pulse_clr();
    chk("clr_overrun", 64'(overrun), 64'd0);

    // Capture on the load cycle: no overrun, old sample now, new one next
    drive_sample(24'h0F0F0F, 24'hF0F0F0);
    wait_pre_load();
    drive_sample(24'h13579B, 24'h2468AC);
    chk("coincide_frame_req", 64'(frame_req), 64'd1);
    chk("coincide_overrun", 64'(overrun), 64'd0);
    sb.push_back(fr(24'h0F0F0F, 24'hF0F0F0));
    wait_fr();
    sb.push_back(fr(24'h13579B, 24'h2468AC));
    chk("coincide_overrun2", 64'(overrun), 64'd0);

    // Mute applies at the frame boundary only
    drive_sample(24'h123456, 24'h0FEDCB);
    wait_fr();
    sb.push_back(fr(24'h123456, 24'h0FEDCB));
    repeat (40) @(negedge audio_clk);
    mute = 1'b1;
    drive_sample(24'h0A5A5A, 24'h5A5A5A);
    wait_fr();
    sb.push_back(fr('0, '0));
    chk("mute_underrun", 64'(underrun), 64'd0);
    chk("mute_overrun", 64'(overrun), 64'd0);
    drive_sample(24'h3C3C3C, 24'h0C30C3);
    repeat (20) @(negedge audio_clk);
    mute = 1'b0;
    wait_fr();
    sb.push_back(fr(24'h3C3C3C, 24'h0C30C3));

    // Asynchronous reset mid right slot
    wait_fr();
    repeat (5) @(negedge audio_clk);
    drive_sample(24'h111111, 24'h111111);
    drive_sample(24'h222222, 24'h222222);
    chk("pre_reset_overrun", 64'(overrun), 64'd1);
    repeat (140) @(negedge audio_clk);
    chk("pre_reset_lrck", 64'(i2s_lrck), 64'd1);
    chk("pre_reset_underrun", 64'(underrun), 64'd1);
    #3 reset_audio = 1'b1;
    #1 chk_zero("midframe_reset");
    sb.delete();
    @(negedge audio_clk);
    release_and_chk_bclk();
    wait_fr();
    sb.push_back(fr('0, '0));
    wait_fr();
    chk("post_reset_underrun", 64'(underrun), 64'd0);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_audio_serializer.md
Name: i2s_audio_serializer

Overview:
- Downstream of the voice mixer; consumes the per-frame stereo sums `lsound_out` / `rsound_out`.
- Buffers one stereo sample and generates the bit clock, word select and serial data for the I2S codec, in standard I2S framing.
- Signals the synthesizer sequencer each time a frame is consumed, and reports sticky underrun/overrun status to the control interface.

Parameters:
- AUD_BIT_DEPTH, 24: sample width in bits; two's-complement, MSB first.
- SLOT_BITS, 32: BCLK periods per channel slot; must be ≥ AUD_BIT_DEPTH+1.
- BCLK_DIV, 4: audio_clk cycles per BCLK half-period; must be ≥ 1.
- CNT_WIDTH, clogb2(2*SLOT_BITS): width of the frame bit counter.

Ports:
- audio_clk, in, 1: single clock; all logic on its rising edge.
- reset_audio, in, 1: asynchronous, active-high reset.
- lsound_in, in, AUD_BIT_DEPTH: left sample from the mixer.
- rsound_in, in, AUD_BIT_DEPTH: right sample from the mixer.
- sample_valid, in, 1: one-cycle strobe; captures lsound_in/rsound_in.
- mute, in, 1: forces zero output, applied frame-aligned.
- flag_clr, in, 1: clears the sticky status flags.
- frame_req, out, 1: one-cycle pulse when the holding buffer is consumed (start of a frame).
- i2s_bclk, out, 1: bit clock.
- i2s_lrck, out, 1: word select; 0 = left, 1 = right.
- i2s_sdata, out, 1: serial data.
- underrun, out, 1: sticky; a frame started with no new sample.
- overrun, out, 1: sticky; an unconsumed sample was overwritten.

Behaviour:
- **Reset values:**
  - div_cnt = 0, i2s_bclk = 0, i2s_lrck = 0, i2s_sdata = 0.
  - bit_cnt = 2*SLOT_BITS-1.
  - Holding buffer: hold_l = hold_r = 0, hold_valid = 0.
  - Active registers: act_l = act_r = 0.
  - armed = 0, frame_req = 0, underrun = 0, overrun = 0.
  - Reset asserted mid-frame abandons the frame immediately; there is no flush.
- **Clock divider:**
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - When div_cnt == BCLK_DIV-1, i2s_bclk toggles.
  - fall_evt is the toggle from 1 to 0.
  - BCLK period = 2*BCLK_DIV clocks; frame period = 4*SLOT_BITS*BCLK_DIV clocks.
- **Bit counter:**
  - On fall_evt, bit_cnt ← (bit_cnt+1) mod 2*SLOT_BITS.
  - Define p = bit_cnt mod SLOT_BITS, evaluated on the new value.
- **Serial outputs (registered, updated only on fall_evt, from the new bit_cnt):**
  - i2s_lrck = (bit_cnt ≥ SLOT_BITS).
  - i2s_sdata = act_x[AUD_BIT_DEPTH-p] for 1 ≤ p ≤ AUD_BIT_DEPTH, where act_x is act_l when lrck = 0 and act_r when lrck = 1.
  - i2s_sdata = 0 for p = 0 and for p > AUD_BIT_DEPTH.
  - Result: the MSB appears one BCLK after the LRCK edge (I2S delay).
- **Frame load:** on a fall_evt where the new bit_cnt == 0, i.e. the wrap:
  - If hold_valid = 1: act ← hold and hold_valid ← 0.
  - Otherwise: act keeps its previous value (the last sample repeats), and underrun ← 1 if armed = 1.
  - If mute = 1: act ← 0, overriding the above, but hold_valid is still cleared so the handshake keeps running.
  - frame_req pulses high for exactly this one cycle.
  - Load and output update are in the same cycle. The first output bit after a load is p = 0 (zero), so act is stable before its MSB is used.
- **Capture:** sample_valid = 1 → hold ← inputs, hold_valid ← 1, armed ← 1.
  - If hold_valid was already 1 and no frame load occurs in that same cycle, overrun ← 1; the new data overwrites the old.
  - Capture and frame load in the same cycle: the load takes the old hold, the new data enters hold, hold_valid stays 1, and no overrun is flagged.
- **Flags:**
  - flag_clr = 1 clears both flags.
  - A set event in the same cycle as flag_clr wins (the flag reads 1 afterwards).
  - Before the first sample_valid, no underrun is flagged.
- **Mute:** asserting or deasserting mid-frame has no effect until the next frame load; there are no partial words.

Test Plan:
- BCLK_DIV=2, defaults. Reset, then sample_valid with L=0x800001, R=0x7FFFFE before the first fall_evt.
  - Frame 0 left slot: bit0 = 0, then 1, 22 zeros, 1, then zeros; lrck = 0.
  - Right slot: 0, 0, 22 ones, 0, then zeros; lrck = 1.
  - frame_req pulses every 256 clocks.
- After reset with no sample_valid: sdata stays 0 for 3 frames, underrun stays 0, and frame_req still pulses.
- Supply one sample, then none: the same word repeats in the next frame and underrun = 1. flag_clr → 0. Then flag_clr coinciding with a new underrun event → reads 1.
- Two sample_valid pulses between frame_req pulses → overrun = 1 and the second sample is transmitted. sample_valid in the same cycle as frame_req → overrun stays 0; the old sample is sent now and the new sample next frame.
- Assert mute mid-left-slot with L=0x123456: the current frame completes unchanged and the next frame is all zeros. Deassert mute → the current hold sample appears at the following frame.
- Assert reset_audio mid-right-slot (asynchronous, not clock-aligned): all outputs go to 0 immediately. After release, timing restarts with bclk rising at clock BCLK_DIV.
